// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of the combinational 16-bit shifter (SLL/SRA/ROR).
// Grants one requester, latches its operands, and returns a registered result with a done pulse.
module shift_arbiter #(
    parameter int RR_EN = 1,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [1:0]    mode0,
    input  logic [3:0]    val0,
    input  logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [1:0]    mode1,
    input  logic [3:0]    val1,
    input  logic [DW-1:0] data1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [DW-1:0] result,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic            rr_ptr, rr_ptr_nxt;
    logic            gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, err_nxt, busy_nxt;
    logic            pick, latch, capture;
    logic [1:0]      op_mode;
    logic [3:0]      op_val;
    logic [DW-1:0]   op_data;

    function automatic logic [DW-1:0] shift_op(input logic [1:0] mode,
                                                input logic [3:0] amt,
                                                input logic [DW-1:0] d);
        logic signed [DW-1:0] sd;
        logic [2*DW-1:0]      dd;
        sd = $signed(d);
        // Rotating the doubled word right leaves the wrapped bits in the low half.
        dd = {d, d} >> amt;
        case (mode)
            2'b00:   shift_op = d << amt;
            2'b01:   shift_op = sd >>> amt;
            2'b10:   shift_op = dd[DW-1:0];
            default: shift_op = '0;
        endcase
    endfunction

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        gnt0_nxt   = gnt0;
        gnt1_nxt   = gnt1;
        done0_nxt  = 1'b0;
        done1_nxt  = 1'b0;
        err_nxt    = 1'b0;
        busy_nxt   = busy;
        pick       = 1'b0;
        latch      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // With both asking, round-robin follows rr_ptr; otherwise the lone requester wins.
                    pick      = (req0 && req1) ? ((RR_EN != 0) ? rr_ptr : 1'b0) : req1;
                    owner_nxt = pick;
                    gnt0_nxt  = !pick;
                    gnt1_nxt  = pick;
                    busy_nxt  = 1'b1;
                    latch     = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                done0_nxt = !owner;
                done1_nxt = owner;
                err_nxt   = (op_mode == 2'b11);
                state_nxt = DONE;
            end
            DONE: begin
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                if (RR_EN != 0) rr_ptr_nxt = !owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            gnt0   <= gnt0_nxt;
            gnt1   <= gnt1_nxt;
            done0  <= done0_nxt;
            done1  <= done1_nxt;
            err    <= err_nxt;
            busy   <= busy_nxt;
        end
    end

    // Operands are frozen at the grant edge; the shifter sees only these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_mode <= 2'b00;
            op_val  <= 4'd0;
            op_data <= '0;
            result  <= '0;
        end else begin
            if (latch) begin
                op_mode <= pick ? mode1 : mode0;
                op_val  <= pick ? val1  : val0;
                op_data <= pick ? data1 : data0;
            end
            if (capture) result <= shift_op(op_mode, op_val, op_data);
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a round-robin instance and a fixed-priority instance share stimulus.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [1:0]  mode0, mode1;
    logic [3:0]  val0, val1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, done0, done1, err, busy;
    logic [15:0] result;
    logic        fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err, fp_busy;
    logic [15:0] fp_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.RR_EN(1), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .mode0(mode0), .val0(val0), .data0(data0),
        .req1(req1), .mode1(mode1), .val1(val1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .result(result), .busy(busy)
    );

    shift_arbiter #(.RR_EN(0), .DW(16)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .mode0(mode0), .val0(val0), .data0(data0),
        .req1(req1), .mode1(mode1), .val1(val1), .data1(data1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1),
        .err(fp_err), .result(fp_result), .busy(fp_busy)
    );

    typedef struct {
        int          port;
        logic [1:0]  mode;
        logic [3:0]  val;
        logic [15:0] data;
        logic [15:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_op(input int p, input logic [1:0] m, input logic [3:0] v,
                         input logic [15:0] d, input logic [15:0] er, input logic ee);
        if (p == 0) begin
            req0 = 1'b1; mode0 = m; val0 = v; data0 = d;
        end else begin
            req1 = 1'b1; mode1 = m; val1 = v; data1 = d;
        end
        tick();
        chk("grant_gnt0", 16'(gnt0), 16'(p == 0));
        chk("grant_gnt1", 16'(gnt1), 16'(p == 1));
        chk("grant_busy", 16'(busy), 16'd1);
        chk("grant_no_done", 16'({done0, done1}), 16'd0);
        tick();
        chk("done0", 16'(done0), 16'(p == 0));
        chk("done1", 16'(done1), 16'(p == 1));
        chk("result", result, er);
        chk("err", 16'(err), 16'(ee));
        chk("fp_result", fp_result, er);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk("idle_gnt", 16'({gnt0, gnt1}), 16'd0);
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_done", 16'({done0, done1, err}), 16'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tbl[0]  = '{0, 2'b00, 4'd4,  16'h00F1, 16'h0F10, 1'b0};
        tbl[1]  = '{1, 2'b01, 4'd3,  16'h8010, 16'hF002, 1'b0};
        tbl[2]  = '{1, 2'b10, 4'd4,  16'h1234, 16'h4123, 1'b0};
        tbl[3]  = '{0, 2'b00, 4'd0,  16'hA5C3, 16'hA5C3, 1'b0};
        tbl[4]  = '{1, 2'b01, 4'd0,  16'h8001, 16'h8001, 1'b0};
        tbl[5]  = '{0, 2'b10, 4'd0,  16'h1234, 16'h1234, 1'b0};
        tbl[6]  = '{0, 2'b01, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
        tbl[7]  = '{1, 2'b01, 4'd4,  16'h7F00, 16'h07F0, 1'b0};
        tbl[8]  = '{0, 2'b10, 4'd1,  16'h0001, 16'h8000, 1'b0};
        tbl[9]  = '{1, 2'b00, 4'd15, 16'h0003, 16'h8000, 1'b0};
        tbl[10] = '{0, 2'b10, 4'd8,  16'hABCD, 16'hCDAB, 1'b0};
        tbl[11] = '{1, 2'b11, 4'd2,  16'hFFFF, 16'h0000, 1'b1};
        tbl[12] = '{0, 2'b00, 4'd1,  16'h8001, 16'h0002, 1'b0};

        rst_n = 1'b0;
        req0 = 1'b0; mode0 = 2'b00; val0 = 4'd0; data0 = 16'h0;
        req1 = 1'b0; mode1 = 2'b00; val1 = 4'd0; data1 = 16'h0;
        tick();
        chk("reset_gnt", 16'({gnt0, gnt1, fp_gnt0, fp_gnt1}), 16'd0);
        chk("reset_done_err", 16'({done0, done1, err}), 16'd0);
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_result", result, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", 16'({gnt0, gnt1, busy}), 16'd0);

        // Single operations on either port, every mode, zero and extreme shift amounts.
        for (int i = 0; i < 13; i++)
            do_op(tbl[i].port, tbl[i].mode, tbl[i].val, tbl[i].data, tbl[i].exp_res, tbl[i].exp_err);

        // Request raised during EXEC/DONE waits until IDLE.
        req0 = 1'b1; mode0 = 2'b00; val0 = 4'd2; data0 = 16'h0011;
        tick();
        req1 = 1'b1; mode1 = 2'b10; val1 = 4'd4; data1 = 16'h000F;
        tick();
        chk("late_done0", 16'(done0), 16'd1);
        chk("late_result", result, 16'h0044);
        chk("late_no_gnt1", 16'(gnt1), 16'd0);
        req0 = 1'b0;
        tick();
        chk("late_idle_gnt1", 16'(gnt1), 16'd0);
        tick();
        chk("late_gnt1", 16'(gnt1), 16'd1);
        tick();
        chk("late_done1", 16'(done1), 16'd1);
        chk("late_result1", result, 16'hF000);
        req1 = 1'b0;
        tick();

        // Abandon: drop req and change operands after the grant edge.
        req0 = 1'b1; mode0 = 2'b00; val0 = 4'd4; data0 = 16'h00F1;
        tick();
        chk("abandon_gnt0", 16'(gnt0), 16'd1);
        req0 = 1'b0; mode0 = 2'b01; data0 = 16'hFFFF; val0 = 4'd9;
        tick();
        chk("abandon_done0", 16'(done0), 16'd1);
        chk("abandon_result", result, 16'h0F10);
        tick();
        tick();
        chk("abandon_no_regrant", 16'({gnt0, gnt1, busy}), 16'd0);
        chk("abandon_result_hold", result, 16'h0F10);

        // Contention: round-robin alternates, fixed priority keeps port 0.
        do_reset();
        req0 = 1'b1; mode0 = 2'b00; val0 = 4'd1; data0 = 16'h0001;
        req1 = 1'b1; mode1 = 2'b00; val1 = 4'd1; data1 = 16'h0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt0", 16'(gnt0), 16'(k % 2 == 0));
            chk("rr_gnt1", 16'(gnt1), 16'(k % 2 == 1));
            chk("fp_gnt", 16'({fp_gnt0, fp_gnt1}), 16'b10);
            tick();
            chk("rr_done", 16'({done0, done1}), (k % 2 == 0) ? 16'b10 : 16'b01);
            chk("rr_result", result, (k % 2 == 0) ? 16'h0002 : 16'h0200);
            chk("fp_done", 16'({fp_done0, fp_done1}), 16'b10);
            tick();
            chk("rr_idle", 16'({gnt0, gnt1, busy}), 16'd0);
        end
        req0 = 1'b0;
        tick();
        chk("fp_gnt1_after_drop", 16'({fp_gnt0, fp_gnt1}), 16'b01);
        chk("rr_gnt1_after_drop", 16'({gnt0, gnt1}), 16'b01);
        tick();
        chk("fp_done1", 16'(fp_done1), 16'd1);
        chk("fp_result1", fp_result, 16'h0200);
        req1 = 1'b0;
        tick();

        // Asynchronous reset in EXEC aborts the op without a done.
        req0 = 1'b1; mode0 = 2'b00; val0 = 4'd4; data0 = 16'h00F1;
        tick();
        chk("pre_abort_gnt0", 16'(gnt0), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", 16'({gnt0, gnt1}), 16'd0);
        chk("abort_done_err", 16'({done0, done1, err}), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_result", result, 16'h0000);
        req0 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("abort_no_resume", 16'({gnt0, gnt1, done0, done1, busy}), 16'd0);
        chk("abort_result_zero", result, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
